// File: rtl/sqr_root_pkg.sv
// rtl/sqr_root_pkg.sv - shared types and width helpers for the sequential square root
package sqr_root_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter holds BW-1 down to 0; never narrower than one bit.
    function automatic int cnt_width(input int bw);
        return (bw > 2) ? $clog2(bw) : 1;
    endfunction

    // Partial remainder needs two guard bits above the root width.
    function automatic int rem_width(input int bw);
        return bw + 2;
    endfunction

endpackage

// File: rtl/sqr_root_step.sv
// rtl/sqr_root_step.sv - one combinational restoring square-root iteration
module sqr_root_step
    import sqr_root_pkg::*;
#(
    parameter int BW = 8
) (
    input  logic [rem_width(BW)-1:0] i_rem,
    input  logic [BW-1:0]            i_root,
    input  logic [1:0]               i_bits,
    output logic [rem_width(BW)-1:0] o_rem,
    output logic [BW-1:0]            o_root
);

    localparam int RW = rem_width(BW);

    logic [RW-1:0] w_shift;
    logic [RW-1:0] w_trial;
    logic          w_ge;

    // Bits shifted out of the remainder are always zero for a valid running state.
    assign w_shift = (i_rem << 2) | {{(RW-2){1'b0}}, i_bits};
    assign w_trial = {i_root, 2'b01};
    assign w_ge    = (w_shift >= w_trial);
    assign o_rem   = w_ge ? (w_shift - w_trial) : w_shift;
    assign o_root  = (i_root << 1) | {{(BW-1){1'b0}}, w_ge};

endmodule

// File: rtl/sqr_sgn_root.sv
// rtl/sqr_sgn_root.sv - handshaked digit-by-digit square root of a signed radicand
module sqr_sgn_root
    import sqr_root_pkg::*;
#(
    parameter int BW = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic signed [2*BW-1:0] X,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [BW-1:0]        Q,
    output logic [BW:0]          R,
    output logic                 neg_o
);

    localparam int CW = cnt_width(BW);
    localparam int RW = rem_width(BW);

    state_t           r_state;
    state_t           w_next_state;
    logic [2*BW-1:0]  r_rad;
    logic [RW-1:0]    r_rem;
    logic [BW-1:0]    r_root;
    logic [CW-1:0]    r_cnt;
    logic             r_neg;
    logic [RW-1:0]    w_rem_nxt;
    logic [BW-1:0]    w_root_nxt;
    logic             w_x_neg;
    logic             w_last;

    assign w_x_neg = X[2*BW-1];
    assign w_last  = (r_cnt == '0);

    sqr_root_step #(
        .BW (BW)
    ) u_step (
        .i_rem  (r_rem),
        .i_root (r_root),
        .i_bits (r_rad[2*BW-1 -: 2]),
        .o_rem  (w_rem_nxt),
        .o_root (w_root_nxt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid_i) begin
                    w_next_state = w_x_neg ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Ready is masked by reset so every output reads zero while reset is held.
    always_comb begin
        in_ready_o  = rst_ni && (r_state == IDLE);
        out_valid_o = (r_state == DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rad  <= '0;
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= '0;
            r_neg  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid_i) begin
                        r_rem  <= '0;
                        r_root <= '0;
                        if (w_x_neg) begin
                            r_neg <= 1'b1;
                        end else begin
                            r_rad <= X;
                            r_cnt <= CW'(BW-1);
                            r_neg <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    r_rem  <= w_rem_nxt;
                    r_root <= w_root_nxt;
                    r_rad  <= {r_rad[2*BW-3:0], 2'b00};
                    if (!w_last) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        r_neg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Q     = r_root;
    assign R     = r_rem[BW:0];
    assign neg_o = r_neg;

endmodule

// File: tb/tb_sqr_sgn_root.sv
// tb/tb_sqr_sgn_root.sv - self-checking bench for sqr_sgn_root
module tb_sqr_sgn_root;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] x_in;
    logic               out_valid;
    logic               out_ready;
    logic [7:0]         q_out;
    logic [8:0]         r_out;
    logic               neg_out;

    int n_chk;
    int n_err;

    typedef struct {
        logic [15:0] x;
        int          edges;
        logic [7:0]  q;
        logic [8:0]  r;
        logic        neg;
    } vec_t;

    vec_t vecs [9];

    sqr_sgn_root #(.BW(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .X           (x_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .Q           (q_out),
        .R           (r_out),
        .neg_o       (neg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_root(input int x);
        int q;
        q = 0;
        while ((q + 1) * (q + 1) <= x) q++;
        return q;
    endfunction

    // Present x, count edges from the accepting edge until out_valid, then release the result.
    task automatic run_one(input logic [15:0] x, output int edges, output logic [7:0] q,
                           output logic [8:0] r, output logic ng, output logic rdy_after);
        @(negedge clk);
        in_valid = 1'b1;
        x_in     = x;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        x_in      = 16'($urandom);
        rdy_after = in_ready;
        edges     = 1;
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        q  = q_out;
        r  = r_out;
        ng = neg_out;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int          edges;
        logic [7:0]  q;
        logic [8:0]  r;
        logic        ng;
        logic        rdy;
        logic [7:0]  q_hold;
        logic [8:0]  r_hold;
        int          xi;
        int          qe;

        n_chk = 0;
        n_err = 0;

        vecs[0] = '{16'd144,   9, 8'd12,  9'd0,  1'b0};
        vecs[1] = '{16'h7FFF,  9, 8'd181, 9'd6,  1'b0};
        vecs[2] = '{16'h4000,  9, 8'd128, 9'd0,  1'b0};
        vecs[3] = '{16'd0,     9, 8'd0,   9'd0,  1'b0};
        vecs[4] = '{16'hFFFF,  1, 8'd0,   9'd0,  1'b1};
        vecs[5] = '{16'h8000,  1, 8'd0,   9'd0,  1'b1};
        vecs[6] = '{16'd1,     9, 8'd1,   9'd0,  1'b0};
        vecs[7] = '{16'd255,   9, 8'd15,  9'd30, 1'b0};
        vecs[8] = '{16'd65535 - 16'd1, 1, 8'd0, 9'd0, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_in      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready",  in_ready,  0);
        check("reset out_valid", out_valid, 0);
        check("reset Q",         q_out,     0);
        check("reset R",         r_out,     0);
        check("reset neg",       neg_out,   0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle in_ready", in_ready, 1);

        for (int i = 0; i < 9; i++) begin
            run_one(vecs[i].x, edges, q, r, ng, rdy);
            check($sformatf("vec%0d latency", i),       edges, vecs[i].edges);
            check($sformatf("vec%0d Q", i),             q,     vecs[i].q);
            check($sformatf("vec%0d R", i),             r,     vecs[i].r);
            check($sformatf("vec%0d neg", i),           ng,    vecs[i].neg);
            check($sformatf("vec%0d ready drop", i),    rdy,   0);
            check($sformatf("vec%0d back idle", i),     in_ready, 1);
        end

        // Backpressure: hold the result while a competing radicand is offered.
        @(negedge clk);
        in_valid = 1'b1;
        x_in     = 16'd1000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        edges = 1;
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("bp latency", edges, 9);
        q_hold = q_out;
        r_hold = r_out;
        check("bp Q", q_hold, 31);
        check("bp R", r_hold, 39);
        in_valid = 1'b1;
        x_in     = 16'h8000;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp%0d out_valid", c), out_valid, 1);
            check($sformatf("bp%0d in_ready", c),  in_ready,  0);
            check($sformatf("bp%0d Q", c),         q_out,     q_hold);
            check($sformatf("bp%0d R", c),         r_out,     r_hold);
            check($sformatf("bp%0d neg", c),       neg_out,   0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("bp release out_valid", out_valid, 0);
        check("bp release in_ready",  in_ready,  1);
        @(posedge clk);
        #1;
        check("bp no accept in_ready", in_ready, 1);
        check("bp no accept neg",      neg_out,  0);

        // Reset mid-BUSY aborts asynchronously.
        @(negedge clk);
        in_valid = 1'b1;
        x_in     = 16'd30000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort in_ready",  in_ready,  0);
        check("abort out_valid", out_valid, 0);
        check("abort Q",         q_out,     0);
        check("abort R",         r_out,     0);
        check("abort neg",       neg_out,   0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_one(16'd200, edges, q, r, ng, rdy);
        check("post-reset latency", edges, 9);
        check("post-reset Q",       q,     14);
        check("post-reset R",       r,     4);
        check("post-reset neg",     ng,    0);

        for (int n = 0; n < 1000; n++) begin
            xi = int'($urandom_range(0, 32767));
            qe = ref_root(xi);
            run_one(16'(xi), edges, q, r, ng, rdy);
            check($sformatf("rnd x=%0d latency", xi), edges, 9);
            check($sformatf("rnd x=%0d Q", xi),       q,     qe);
            check($sformatf("rnd x=%0d R", xi),       r,     xi - qe * qe);
            check($sformatf("rnd x=%0d neg", xi),     ng,    0);
        end

        for (int n = 0; n < 50; n++) begin
            xi = int'($urandom_range(32768, 65535));
            run_one(16'(xi), edges, q, r, ng, rdy);
            check($sformatf("rndneg x=%0d latency", xi), edges, 1);
            check($sformatf("rndneg x=%0d Q", xi),       q,     0);
            check($sformatf("rndneg x=%0d R", xi),       r,     0);
            check($sformatf("rndneg x=%0d neg", xi),     ng,    1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
